// File: rtl/receive.sv
// UART receiver: 8N1 frames (8E1 when RECEIVE_PARITY_EN is defined) oversampled in the clk domain.
// Latency: valid rises 3 + HALF + 9*DIV clk cycles after the rxd falling edge (one DIV more with parity).
// Backpressure: one-entry output; a byte completing while valid && !ready is dropped with an overrun pulse.
module receive #(
    parameter real BAUD = 96e2,
    parameter real FREQ = 12e6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       parity_error
);

    localparam int DIV  = $rtoi(FREQ / BAUD + 0.5);
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RECEIVE_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          armed, armed_nxt;
    logic          sync1, rxd_s;
    logic [7:0]    data_nxt;
    logic          valid_nxt;
    logic          fe_nxt, ov_nxt;
    logic          cnt_done, half_done;

    assign cnt_done  = (cnt == CW'(DIV - 1));
    assign half_done = (cnt == CW'(HALF - 1));

`ifdef RECEIVE_PARITY_EN
    logic par_bad, par_bad_nxt;
    logic pe_nxt;
`else
    assign parity_error = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        armed_nxt = armed;
        data_nxt  = data;
        valid_nxt = valid;
        fe_nxt    = 1'b0;
        ov_nxt    = 1'b0;
`ifdef RECEIVE_PARITY_EN
        par_bad_nxt = par_bad;
        pe_nxt      = 1'b0;
`endif
        if (valid && ready) begin
            valid_nxt = 1'b0;
        end
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                // After a framing error the line must go high again before a new start is accepted
                if (rxd_s) begin
                    armed_nxt = 1'b1;
                end else if (armed) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (half_done) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_done) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rxd_s, shift[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef RECEIVE_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef RECEIVE_PARITY_EN
            PARITY: begin
                if (cnt_done) begin
                    cnt_nxt     = '0;
                    par_bad_nxt = (rxd_s != ^shift);
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_done) begin
                    // Back to IDLE mid-stop-bit so a zero-gap start edge is not missed
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (!rxd_s) begin
                        fe_nxt    = 1'b1;
                        armed_nxt = 1'b0;
`ifdef RECEIVE_PARITY_EN
                    end else if (par_bad) begin
                        pe_nxt = 1'b1;
`endif
                    end else if (valid && !ready) begin
                        ov_nxt = 1'b1;
                    end else begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1       <= 1'b1;
            rxd_s       <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            armed       <= 1'b1;
            data        <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sync1       <= rxd;
            rxd_s       <= sync1;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_nxt;
            shift       <= shift_nxt;
            armed       <= armed_nxt;
            data        <= data_nxt;
            valid       <= valid_nxt;
            frame_error <= fe_nxt;
            overrun     <= ov_nxt;
        end
    end

`ifdef RECEIVE_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad      <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            par_bad      <= par_bad_nxt;
            parity_error <= pe_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_receive.sv
// Bench for receive: frame driver, event-level reference model and per-cycle output compare.
module tb_receive;

    localparam int DIV  = 16;
    localparam int HALF = 8;
`ifdef RECEIVE_PARITY_EN
    localparam int NBITS   = 11;
    localparam int LAT     = 3 + HALF + 10 * DIV;
    localparam int LAT_LIT = 171;
`else
    localparam int NBITS   = 10;
    localparam int LAT     = 3 + HALF + 9 * DIV;
    localparam int LAT_LIT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, frame_error, overrun, parity_error;

    receive #(.BAUD(750000.0), .FREQ(12.0e6)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid), .ready(ready),
        .frame_error(frame_error), .overrun(overrun), .parity_error(parity_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ready: fixed level or random per cycle, always changed just after posedge
    logic ready_fix = 1'b1;
    logic ready_rnd = 1'b0;
    always @(posedge clk) begin
        #1;
        ready = ready_rnd ? 1'($urandom_range(0, 1)) : ready_fix;
    end

    typedef struct {
        int         at;
        int         kind;   // 0 good, 1 bad stop, 2 bad parity
        logic [7:0] b;
    } ev_t;
    ev_t        sched[$];
    logic [7:0] rx_log[$];
    int         t0_last = 0;

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * DIV) @(posedge clk);
        #1;
    endtask

    task automatic drive_bits(input logic [11:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            rxd = v[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_ok);
        logic [11:0] v;
        int          kind;
`ifdef RECEIVE_PARITY_EN
        v = {1'b0, stop, (^b) ^ ~par_ok, b, 1'b0};
`else
        v = {2'b00, stop, b, 1'b0};
`endif
        kind    = !stop ? 1 : (!par_ok ? 2 : 0);
        t0_last = cyc;
        sched.push_back('{cyc + LAT, kind, b});
        drive_bits(v, NBITS);
    endtask

    // Reference model: one frame resolves at its stop-sample edge; one holding slot for the consumer
    logic       m_valid = 1'b0, m_fe = 1'b0, m_ov = 1'b0, m_pe = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       rdy_prev = 1'b1;
    logic       old_valid;
    logic       dut_valid_d = 1'b0;
    ev_t        ev;
    int         rise_cyc = 0;
    int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;

    always @(negedge clk) begin
        m_fe = 1'b0;
        m_ov = 1'b0;
        m_pe = 1'b0;
        if (!rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            sched.delete();
        end else begin
            old_valid = m_valid;
            if (m_valid && rdy_prev) begin
                rx_log.push_back(m_data);
                m_valid = 1'b0;
            end
            if (sched.size() > 0 && sched[0].at == cyc) begin
                ev = sched.pop_front();
                case (ev.kind)
                    0: if (old_valid && !rdy_prev) m_ov = 1'b1;
                       else begin
                           m_data  = ev.b;
                           m_valid = 1'b1;
                       end
                    1: m_fe = 1'b1;
                    default: m_pe = 1'b1;
                endcase
            end
        end
        chk("outputs{pe,ov,fe,valid,data}", {20'd0, parity_error, overrun, frame_error, valid, data},
            {20'd0, m_pe, m_ov, m_fe, m_valid, m_data});
        if (valid && !dut_valid_d) rise_cyc = cyc;
        dut_valid_d = valid;
        if (frame_error) fe_cnt++;
        if (overrun) ov_cnt++;
        if (parity_error) pe_cnt++;
        rdy_prev = ready;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int         n0;
    logic [7:0] b1, b2;

    initial begin
        repeat (4) @(posedge clk);
        #1;
        chk("reset_data", 32'(data), 32'h00);
        chk("reset_valid", 32'(valid), 32'h0);
        rst = 1'b1;

        // single frame after long idle
        idle_bits(10);
        send_byte(8'hA5, 1'b1, 1'b1);
        idle_bits(2);
        chk("a5_count", rx_log.size(), 1);
        if (rx_log.size() >= 1) chk("a5_data", 32'(rx_log[0]), 32'hA5);
        chk("a5_latency", rise_cyc - t0_last, LAT_LIT);
        chk("a5_no_errors", fe_cnt + ov_cnt + pe_cnt, 0);

        // zero-gap random pair
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        send_byte(b1, 1'b1, 1'b1);
        send_byte(b2, 1'b1, 1'b1);
        idle_bits(2);
        chk("b2b_count", rx_log.size(), 3);
        if (rx_log.size() >= 3) begin
            chk("b2b_first", 32'(rx_log[1]), 32'(b1));
            chk("b2b_second", 32'(rx_log[2]), 32'(b2));
        end

        // overrun with consumer stalled
        ready_fix = 1'b0;
        idle_bits(1);
        send_byte(8'h3C, 1'b1, 1'b1);
        send_byte(8'hC3, 1'b1, 1'b1);
        idle_bits(1);
        chk("ovr_data_held", 32'(data), 32'h3C);
        chk("ovr_valid_held", 32'(valid), 32'h1);
        chk("ovr_pulses", ov_cnt, 1);
        ready_fix = 1'b1;
        idle_bits(1);
        chk("ovr_valid_drop", 32'(valid), 32'h0);
        if (rx_log.size() >= 1) chk("ovr_consumed", 32'(rx_log[rx_log.size() - 1]), 32'h3C);
        chk("ovr_count", rx_log.size(), 4);

        // framing error, recovery after line returns high
        send_byte(8'h55, 1'b0, 1'b1);
        idle_bits(2);
        chk("fe_pulses", fe_cnt, 1);
        chk("fe_no_byte", rx_log.size(), 4);
        send_byte(8'h0F, 1'b1, 1'b1);
        idle_bits(2);
        chk("fe_recover_count", rx_log.size(), 5);
        if (rx_log.size() >= 5) chk("fe_recover_data", 32'(rx_log[4]), 32'h0F);

        // short low glitch
        rxd = 1'b0;
        repeat (HALF / 2) @(posedge clk);
        #1;
        idle_bits(3);
        chk("glitch_no_byte", rx_log.size(), 5);
        chk("glitch_no_err", fe_cnt + ov_cnt + pe_cnt, 2);

        // reset in the middle of a frame
        drive_bits({7'd0, 4'b0110, 1'b0}, 5);
        rst = 1'b0;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_data", 32'(data), 32'h00);
        chk("midrst_valid", 32'(valid), 32'h0);
        rst = 1'b1;
        idle_bits(2);
        send_byte(8'h81, 1'b1, 1'b1);
        idle_bits(2);
        chk("midrst_count", rx_log.size(), 6);
        if (rx_log.size() >= 6) chk("midrst_data_81", 32'(rx_log[5]), 32'h81);

`ifdef RECEIVE_PARITY_EN
        send_byte(8'h01, 1'b1, 1'b0);
        idle_bits(2);
        chk("par_pulses", pe_cnt, 1);
        chk("par_no_byte", rx_log.size(), 6);
`endif

        // randomized traffic with random consumer stalls
        ready_rnd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'($urandom), 1'b1, 1'b1);
            if ($urandom_range(0, 2) != 0) idle_bits($urandom_range(0, 2));
        end
        ready_rnd = 1'b0;
        ready_fix = 1'b1;
        idle_bits(3);
        n0 = rx_log.size();
        chk("rand_drained_valid", 32'(valid), 32'h0);
        chk("rand_some_bytes", 32'(n0 > 6), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
